// File: rtl/rx_packet_framer_pkg.sv
// rx_framer_pkg: shared framing limits, FSM state codes and verdict indices for the RX packet framer.
package rx_framer_pkg;
    localparam int DLLP_LEN    = 6;
    localparam int TLP_MIN_LEN = 18;
    localparam int TLP_MAX_LEN = 4126;
    localparam int LEN_W       = 13;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_TLP  = 2'd1;
    localparam logic [1:0] ST_DLLP = 2'd2;

    localparam int V_TLP  = 0;
    localparam int V_NULL = 1;
    localparam int V_DLLP = 2;
    localparam int V_ERR  = 3;
    localparam int NV     = 4;
endpackage

// File: rtl/rx_packet_framer_if.sv
// rx_packet_framer_if: one beat of byte data plus per-byte content and boundary masks.
interface rx_packet_framer_if #(parameter int NBYTES = 64);
    logic                valid;
    logic [8*NBYTES-1:0] data;
    logic [NBYTES-1:0]   bvalid;
    logic [NBYTES-1:0]   tlpstart;
    logic [NBYTES-1:0]   tlpend;
    logic [NBYTES-1:0]   tlpedb;
    logic [NBYTES-1:0]   dlpstart;
    logic [NBYTES-1:0]   dlpend;

    modport master (output valid, data, bvalid, tlpstart, tlpend, tlpedb, dlpstart, dlpend);
    modport slave  (input  valid, data, bvalid, tlpstart, tlpend, tlpedb, dlpstart, dlpend);
endinterface

// File: rtl/rx_packet_framer_sat_counter.sv
// rx_sat_counter: accumulates the popcount of a byte mask each enabled cycle, saturating at all-ones.
module rx_sat_counter #(
    parameter int CNT_W  = 16,
    parameter int NBYTES = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [NBYTES-1:0] mask,
    output logic [CNT_W-1:0]  cnt
);
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic [CNT_W:0]   sum;

    always_comb begin
        sum = {1'b0, cnt_q};
        for (int i = 0; i < NBYTES; i++) sum = sum + {{CNT_W{1'b0}}, mask[i]};
        cnt_d = !en ? cnt_q : sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;
endmodule

// File: rtl/rx_packet_framer.sv
// rx_packet_framer: per-byte TLP/DLLP framing and length checker with a one-cycle registered
// output stage and saturating verdict counters.
module rx_packet_framer
    import rx_framer_pkg::*;
#(
    parameter int NBYTES = 64,
    parameter int CNT_W  = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               linkup,
    rx_packet_framer_if.slave  in_if,
    rx_packet_framer_if.master out_if,
    output logic [NBYTES-1:0]  out_tlp_ok,
    output logic [NBYTES-1:0]  out_tlp_null,
    output logic [NBYTES-1:0]  out_dllp_ok,
    output logic [NBYTES-1:0]  out_err,
    output logic [CNT_W-1:0]   cnt_tlp,
    output logic [CNT_W-1:0]   cnt_null,
    output logic [CNT_W-1:0]   cnt_dllp,
    output logic [CNT_W-1:0]   cnt_err
);
    logic [1:0]                st_q, st_d, st_c;
    logic [LEN_W-1:0]          len_q, len_d, len_c;
    logic                      stray_q, stray_d, stray_c;
    logic [NV-1:0][NBYTES-1:0] vd_c, vd_d, vd_q;
    logic [5:0][NBYTES-1:0]    msk_d, msk_q;
    logic [8*NBYTES-1:0]       data_d, data_q;
    logic                      valid_d, valid_q, beat;
    logic                      ts, ds, te, tx, de, eop, ok;

    assign beat = in_if.valid & linkup;

    always_comb begin
        st_c    = st_q;
        len_c   = len_q;
        stray_c = stray_q;
        vd_c    = '0;
        {ts, ds, te, tx, de, eop, ok} = '0;
        for (int i = 0; i < NBYTES; i++) begin
            ts  = in_if.tlpstart[i];
            ds  = in_if.dlpstart[i];
            te  = in_if.tlpend[i];
            tx  = in_if.tlpedb[i];
            de  = in_if.dlpend[i];
            eop = te | tx | de;
            if (!in_if.bvalid[i]) begin
                stray_c = 1'b0;
            end else if (ts & ds) begin
                vd_c[V_ERR][i] = 1'b1;
                st_c    = ST_IDLE;
                len_c   = '0;
                stray_c = 1'b0;
            end else if (ts | ds) begin
                vd_c[V_ERR][i] = st_c != ST_IDLE;
                st_c    = ts ? ST_TLP : ST_DLLP;
                len_c   = LEN_W'(1);
                stray_c = 1'b0;
            end else if (st_c != ST_IDLE) begin
                len_c = len_c + LEN_W'(1);
                if (len_c == LEN_W'(TLP_MAX_LEN + 1)) begin
                    vd_c[V_ERR][i] = 1'b1;
                    st_c    = ST_IDLE;
                    len_c   = '0;
                    stray_c = 1'b1;
                end
            end else begin
                // stray content: flag the first byte of each run, but every misplaced end marker
                vd_c[V_ERR][i] = eop | !stray_c;
                stray_c = 1'b1;
            end
            if (in_if.bvalid[i] && eop && st_c != ST_IDLE) begin
                ok = st_c == ST_TLP ? (te ^ tx) & !de & (len_c >= LEN_W'(TLP_MIN_LEN)) & (len_c[1:0] == 2'd2)
                                    : de & !te & !tx & (len_c == LEN_W'(DLLP_LEN));
                ok = ok & !vd_c[V_ERR][i];
                vd_c[V_ERR][i]  = !ok;
                vd_c[V_TLP][i]  = ok & (st_c == ST_TLP) & te;
                vd_c[V_NULL][i] = ok & (st_c == ST_TLP) & tx;
                vd_c[V_DLLP][i] = ok & (st_c == ST_DLLP);
                st_c  = ST_IDLE;
                len_c = '0;
            end
        end
        st_d    = !linkup ? ST_IDLE : in_if.valid ? st_c : st_q;
        len_d   = !linkup ? '0 : in_if.valid ? len_c : len_q;
        stray_d = linkup & (in_if.valid ? stray_c : stray_q);
        valid_d = beat;
        data_d  = beat ? in_if.data : '0;
        msk_d   = beat ? {in_if.dlpend, in_if.dlpstart, in_if.tlpedb, in_if.tlpend, in_if.tlpstart, in_if.bvalid} : '0;
        vd_d    = beat ? vd_c : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q    <= ST_IDLE;
            len_q   <= '0;
            stray_q <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
            msk_q   <= '0;
            vd_q    <= '0;
        end else begin
            st_q    <= st_d;
            len_q   <= len_d;
            stray_q <= stray_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            msk_q   <= msk_d;
            vd_q    <= vd_d;
        end
    end

    assign out_if.valid    = valid_q;
    assign out_if.data     = data_q;
    assign out_if.bvalid   = msk_q[0];
    assign out_if.tlpstart = msk_q[1];
    assign out_if.tlpend   = msk_q[2];
    assign out_if.tlpedb   = msk_q[3];
    assign out_if.dlpstart = msk_q[4];
    assign out_if.dlpend   = msk_q[5];
    assign out_tlp_ok      = vd_q[V_TLP];
    assign out_tlp_null    = vd_q[V_NULL];
    assign out_dllp_ok     = vd_q[V_DLLP];
    assign out_err         = vd_q[V_ERR];

    rx_sat_counter #(.CNT_W(CNT_W), .NBYTES(NBYTES)) u_cnt_tlp (
        .clk(clk), .rst_n(rst_n), .en(beat), .mask(vd_c[V_TLP]), .cnt(cnt_tlp));
    rx_sat_counter #(.CNT_W(CNT_W), .NBYTES(NBYTES)) u_cnt_null (
        .clk(clk), .rst_n(rst_n), .en(beat), .mask(vd_c[V_NULL]), .cnt(cnt_null));
    rx_sat_counter #(.CNT_W(CNT_W), .NBYTES(NBYTES)) u_cnt_dllp (
        .clk(clk), .rst_n(rst_n), .en(beat), .mask(vd_c[V_DLLP]), .cnt(cnt_dllp));
    rx_sat_counter #(.CNT_W(CNT_W), .NBYTES(NBYTES)) u_cnt_err (
        .clk(clk), .rst_n(rst_n), .en(beat), .mask(vd_c[V_ERR]), .cnt(cnt_err));
endmodule
